// File: rtl/io_uart_bridge.sv
// Memory-mapped UART on the stack machine I/O bus: TXDATA/STATUS/RXDATA registers,
// TX FIFO feeding an 8N1 serializer, and a synchronized 8N1 deserializer with a one-byte holding register.
module io_uart_bridge #(
    parameter int                    DATA_WIDTH   = 16,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 16'h4000,
    parameter int                    CLKS_PER_BIT = 217,
    parameter int                    FIFO_DEPTH   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] io_addr,
    input  logic                  io_write,
    input  logic [DATA_WIDTH-1:0] io_wr_data,
    output logic [DATA_WIDTH-1:0] io_rd_data,
    output logic                  uart_tx,
    input  logic                  uart_rx,
    output logic [1:0]            tx_state_dbg,
    output logic [1:0]            rx_state_dbg
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   FILL_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   FILL_MAX = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

    logic       sel;
    logic [1:0] off;
    logic       wr_txdata, wr_status, wr_rxdata;
    logic       unused_wr_bits;

    assign sel            = (io_addr[DATA_WIDTH-1:2] == BASE_ADDR[DATA_WIDTH-1:2]);
    assign off            = io_addr[1:0];
    assign wr_txdata      = io_write && sel && (off == 2'd0);
    assign wr_status      = io_write && sel && (off == 2'd1);
    assign wr_rxdata      = io_write && sel && (off == 2'd2);
    assign unused_wr_bits = ^io_wr_data[DATA_WIDTH-1:8];

    // TX FIFO: a push while full is dropped; push and pop together leave the fill unchanged.
    logic [7:0]    fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          fifo_full, fifo_empty, push, pop;

    assign fifo_full  = (count_q == FILL_MAX);
    assign fifo_empty = (count_q == '0);
    assign push       = wr_txdata && !fifo_full;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= io_wr_data[7:0];
                wr_ptr_q             <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + FILL_ONE;
                2'b01:   count_q <= count_q - FILL_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    uart_state_e   tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_q, tx_d;
    logic          tx_busy;

    // tx_d is the line level for the next cycle, so every bit spans exactly CLKS_PER_BIT cycles.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    tx_shift_d = fifo_mem_q[rd_ptr_q];
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = 1'b0;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_state_d = S_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = S_STOP;
                    end else begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            S_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = S_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    assign tx_busy = (tx_state_q != S_IDLE) || !fifo_empty;

    logic          sync1_q, sync2_q;
    uart_state_e   rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_overrun_q, rx_overrun_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          frame_ok, rx_load, rx_ovr;

    // The falling edge is seen in IDLE, so START counts from 1 and samples CLKS_PER_BIT/2 into the bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        frame_ok   = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (!sync2_q) begin
                    rx_cnt_d   = CNT_ONE;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (rx_cnt_q == BIT_HALF) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = sync2_q ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {sync2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = S_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            S_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    frame_ok   = sync2_q;
                    rx_state_d = S_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // rx_valid is the holding register's valid; an RXDATA write is the consumer's ack,
    // and an ack in the completion cycle frees the slot for the arriving byte.
    always_comb begin
        rx_load      = frame_ok && (!rx_valid_q || wr_rxdata);
        rx_ovr       = frame_ok && rx_valid_q && !wr_rxdata;
        rx_byte_d    = rx_load ? rx_shift_q : rx_byte_q;
        rx_valid_d   = rx_load ? 1'b1 : (wr_rxdata ? 1'b0 : rx_valid_q);
        rx_overrun_d = rx_ovr ? 1'b1 : (wr_status ? 1'b0 : rx_overrun_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_q   <= S_IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
            tx_q         <= 1'b1;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            rx_state_q   <= S_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            rx_byte_q    <= '0;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            tx_q         <= tx_d;
            sync1_q      <= uart_rx;
            sync2_q      <= sync1_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
            rx_byte_q    <= rx_byte_d;
        end
    end

    always_comb begin
        io_rd_data = '0;
        if (sel) begin
            case (off)
                2'd0:    io_rd_data = DATA_WIDTH'(count_q);
                2'd1:    io_rd_data[4:0] = {rx_overrun_q, rx_valid_q, tx_busy, fifo_empty, fifo_full};
                2'd2:    io_rd_data[7:0] = rx_byte_q;
                default: io_rd_data = '0;
            endcase
        end
    end

    assign uart_tx      = tx_q;
    assign tx_state_dbg = tx_state_q;
    assign rx_state_dbg = rx_state_q;

endmodule

// File: tb/tb_io_uart_bridge.sv
// Bench for io_uart_bridge: a queue-based line/register model checked every cycle,
// directed scenarios with literal expectations, and a randomized register/RX phase.
module tb_io_uart_bridge;

    localparam int          C      = 4;
    localparam int          DEPTH  = 8;
    localparam int          FRAME  = 10 * C + 1;
    localparam int          RX_LAT = 3 + C / 2 + 9 * C;
    localparam logic [15:0] BASE   = 16'h4000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] io_addr = 16'h4001;
    logic        io_write = 1'b0;
    logic [15:0] io_wr_data = 16'h0000;
    logic [15:0] io_rd_data;
    logic        uart_tx;
    logic        uart_rx = 1'b1;
    logic [1:0]  tx_state_dbg;
    logic [1:0]  rx_state_dbg;

    io_uart_bridge #(
        .DATA_WIDTH  (16),
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .io_addr     (io_addr),
        .io_write    (io_write),
        .io_wr_data  (io_wr_data),
        .io_rd_data  (io_rd_data),
        .uart_tx     (uart_tx),
        .uart_rx     (uart_rx),
        .tx_state_dbg(tx_state_dbg),
        .rx_state_dbg(rx_state_dbg)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         due;
        logic [7:0] b;
        bit         stop_ok;
    } rx_evt_t;

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    logic       wave_q[$];
    rx_evt_t    rx_evt_q[$];
    logic [7:0] tx_seen[$];
    logic       m_tx = 1'b1;
    logic       m_rx_valid = 1'b0;
    logic       m_rx_overrun = 1'b0;
    logic [7:0] m_rx_byte = 8'h00;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] a);
        logic [15:0] r;
        logic        busy;
        r    = 16'h0000;
        busy = (wave_q.size() != 0) || (exp_q.size() != 0);
        if (a[15:2] == BASE[15:2]) begin
            case (a[1:0])
                2'd0:    r = 16'(exp_q.size());
                2'd1:    r = {11'b0, m_rx_overrun, m_rx_valid, busy,
                              exp_q.size() == 0, exp_q.size() == DEPTH};
                2'd2:    r = {8'h00, m_rx_byte};
                default: r = 16'h0000;
            endcase
        end
        return r;
    endfunction

    // Model: the FIFO is a byte queue; a taken byte becomes its line waveform (start, 8 data, stop, one idle cycle).
    initial begin
        forever begin
            logic       full_before, sel, wr_tx, wr_st, wr_rx, loaded, ovr;
            logic [7:0] b;
            rx_evt_t    e;
            @(posedge clock);
            cyc++;
            if (reset) begin
                exp_q.delete();
                wave_q.delete();
                rx_evt_q.delete();
                m_tx         = 1'b1;
                m_rx_valid   = 1'b0;
                m_rx_overrun = 1'b0;
                m_rx_byte    = 8'h00;
            end else begin
                full_before = (exp_q.size() == DEPTH);
                if (wave_q.size() == 0 && exp_q.size() != 0) begin
                    b = exp_q.pop_front();
                    for (int i = 0; i < C; i++) wave_q.push_back(1'b0);
                    for (int k = 0; k < 8; k++)
                        for (int i = 0; i < C; i++) wave_q.push_back(b[k]);
                    for (int i = 0; i < C + 1; i++) wave_q.push_back(1'b1);
                end
                m_tx  = (wave_q.size() != 0) ? wave_q.pop_front() : 1'b1;
                sel   = (io_addr[15:2] == BASE[15:2]);
                wr_tx = io_write && sel && (io_addr[1:0] == 2'd0);
                wr_st = io_write && sel && (io_addr[1:0] == 2'd1);
                wr_rx = io_write && sel && (io_addr[1:0] == 2'd2);
                if (wr_tx && !full_before) exp_q.push_back(io_wr_data[7:0]);
                loaded = 1'b0;
                ovr    = 1'b0;
                if (rx_evt_q.size() != 0 && rx_evt_q[0].due == cyc) begin
                    e = rx_evt_q.pop_front();
                    if (e.stop_ok) begin
                        if (!m_rx_valid || wr_rx) begin
                            m_rx_byte = e.b;
                            loaded    = 1'b1;
                        end else begin
                            ovr = 1'b1;
                        end
                    end
                end
                if (loaded) m_rx_valid = 1'b1;
                else if (wr_rx) m_rx_valid = 1'b0;
                if (ovr) m_rx_overrun = 1'b1;
                else if (wr_st) m_rx_overrun = 1'b0;
            end
        end
    end

    initial begin
        @(posedge clock);
        forever begin
            @(negedge clock);
            check("uart_tx", uart_tx, m_tx);
            check("io_rd_data", io_rd_data, model_read(io_addr));
        end
    end

    // Independent line decoder: mid-bit sampling of uart_tx into tx_seen.
    initial begin
        forever begin
            logic [7:0] b;
            logic       stop_bit;
            @(negedge clock);
            if (!reset && uart_tx === 1'b0) begin
                repeat (C / 2) @(negedge clock);
                for (int k = 0; k < 8; k++) begin
                    repeat (C) @(negedge clock);
                    b[k] = uart_tx;
                end
                repeat (C) @(negedge clock);
                stop_bit = uart_tx;
                if (stop_bit === 1'b1) tx_seen.push_back(b);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, %0d vectors, %0d miscompares", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        io_addr    = a;
        io_wr_data = d;
        io_write   = 1'b1;
        @(posedge clock);
        #1;
        io_write = 1'b0;
    endtask

    task automatic rd_check(input logic [15:0] a, input logic [15:0] exp, input string name);
        io_addr = a;
        @(negedge clock);
        check(name, io_rd_data, exp);
        @(posedge clock);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop_ok);
        rx_evt_t e;
        e.due     = cyc + RX_LAT;
        e.b       = b;
        e.stop_ok = stop_ok;
        rx_evt_q.push_back(e);
        uart_rx = 1'b0;
        idle(C);
        for (int k = 0; k < 8; k++) begin
            uart_rx = b[k];
            idle(C);
        end
        uart_rx = stop_ok;
        idle(C);
        uart_rx = 1'b1;
        idle(C);
    endtask

    initial begin
        logic [9:0] exp55;
        exp55 = 10'b1010101010;

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_uart_tx", uart_tx, 1'b1);
        rd_check(16'h4001, 16'h0002, "reset_status");
        rd_check(16'h4000, 16'h0000, "reset_count");
        rd_check(16'h4002, 16'h0000, "reset_rxdata");
        rd_check(16'h4003, 16'h0000, "off3_read");

        // single 0x55 frame, bit by bit
        wr(16'h4000, 16'h0055);
        io_addr = 16'h4001;
        @(posedge clock);
        for (int j = 0; j < 10 * C; j++) begin
            @(negedge clock);
            check("frame55_bit", uart_tx, exp55[j / C]);
            check("frame55_busy", io_rd_data[2], 1'b1);
        end
        @(posedge clock);
        @(negedge clock);
        check("status_after_frame", io_rd_data, 16'h0002);
        @(posedge clock);
        #1;
        idle(2);
        check("tx_seen_55", {tx_seen.size(), (tx_seen.size() != 0) ? tx_seen[0] : 8'h00},
              {32'd1, 8'h55});
        tx_seen.delete();

        // overfill the FIFO while the serializer holds a frame
        wr(16'h4000, 16'h00F0);
        idle(2);
        for (int i = 1; i <= 9; i++) wr(16'h4000, 16'(i));
        rd_check(16'h4000, 16'h0008, "fifo_count_full");
        rd_check(16'h4001, 16'h0005, "status_full");
        wr(16'h4003, 16'h00AA);
        idle(9 * FRAME + 20);
        check("tx_seen_count", tx_seen.size(), 9);
        for (int i = 0; i < 9; i++)
            if (i < tx_seen.size())
                check("tx_seen_byte", tx_seen[i], (i == 0) ? 8'hF0 : 8'(i));
        tx_seen.delete();
        rd_check(16'h4001, 16'h0002, "status_drained");

        // RX receive and ack
        send_rx(8'hA3, 1'b1);
        rd_check(16'h4001, 16'h000A, "rx_status_valid");
        rd_check(16'h4002, 16'h00A3, "rx_byte_a3");
        wr(16'h4002, 16'h0000);
        rd_check(16'h4001, 16'h0002, "rx_after_ack");

        // overrun
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        rd_check(16'h4002, 16'h0011, "rx_keeps_first");
        rd_check(16'h4001, 16'h001A, "status_overrun");
        wr(16'h4001, 16'h0000);
        rd_check(16'h4001, 16'h000A, "overrun_cleared");
        wr(16'h4002, 16'h0000);
        rd_check(16'h4001, 16'h0002, "rx_acked2");

        // glitch, then a framing error
        uart_rx = 1'b0;
        idle(1);
        uart_rx = 1'b1;
        idle(2 * C + 4);
        send_rx(8'h5A, 1'b0);
        rd_check(16'h4001, 16'h0002, "framing_no_valid");
        check("rx_fsm_idle", rx_state_dbg, 2'd0);

        // randomized register traffic alongside random RX frames
        fork
            begin
                repeat (300) begin
                    case ($urandom_range(0, 9))
                        0, 1, 2, 3: wr(16'h4000, 16'($urandom));
                        4:          wr(16'h4001, 16'($urandom));
                        5:          wr(16'h4002, 16'($urandom));
                        6:          wr(16'h4003, 16'($urandom));
                        7:          wr(16'($urandom), 16'($urandom));
                        default:    io_addr = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                              : {BASE[15:2], 2'($urandom_range(0, 3))};
                    endcase
                    idle($urandom_range(1, 20));
                end
            end
            begin
                repeat (12) begin
                    send_rx(8'($urandom), $urandom_range(0, 5) != 0);
                    idle($urandom_range(0, 30));
                end
            end
        join
        io_addr = 16'h4001;
        idle(DEPTH * FRAME + FRAME + 50);
        wr(16'h4002, 16'h0000);
        wr(16'h4001, 16'h0000);
        rd_check(16'h4001, 16'h0002, "status_after_random");

        // reset in the DATA phase with three bytes queued
        wr(16'h4000, 16'h0031);
        wr(16'h4000, 16'h0032);
        wr(16'h4000, 16'h0033);
        wr(16'h4000, 16'h0034);
        rd_check(16'h4000, 16'h0003, "queued_three");
        idle(3);
        check("tx_in_data", tx_state_dbg, 2'd2);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset   = 1'b0;
        io_addr = 16'h4000;
        @(negedge clock);
        check("tx_after_reset", uart_tx, 1'b1);
        check("count_after_reset", io_rd_data, 16'h0000);
        @(posedge clock);
        #1;
        rd_check(16'h0005, 16'h0000, "unselected_read");
        for (int j = 0; j < 3 * FRAME; j++) begin
            @(negedge clock);
            check("tx_quiet", uart_tx, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
